// File: rtl/fg_vram_arbiter_pkg.sv
// Shared types and constants for the foreground VRAM arbiter.
// Slots 6 and 7 of every 8-pixel tile column belong to video fetch.
package fg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_DONE
    } arb_state_t;

    localparam logic [2:0] VID_SLOT_FIRST = 3'd6;
    localparam logic [2:0] VID_SLOT_LAST  = 3'd7;

    function automatic logic is_vid_slot(input logic [2:0] slot);
        return slot >= VID_SLOT_FIRST;
    endfunction

endpackage

// File: rtl/fg_vram_arbiter_if.sv
// Z80 side of the foreground tile RAM: selects, strobes, address/data and the
// wait line returned to the CPU.
interface fg_vram_arbiter_if;

    logic        CHARAM_n;
    logic        ATRRAM_n;
    logic        Z80_RD_n;
    logic        Z80_WR_n;
    logic [10:0] CPU_ADDR;
    logic [7:0]  CPU_DIN;
    logic [7:0]  cpu_dout;
    logic        FG_WAIT_n;

    modport master (
        output CHARAM_n, ATRRAM_n, Z80_RD_n, Z80_WR_n, CPU_ADDR, CPU_DIN,
        input  cpu_dout, FG_WAIT_n
    );

    modport slave (
        input  CHARAM_n, ATRRAM_n, Z80_RD_n, Z80_WR_n, CPU_ADDR, CPU_DIN,
        output cpu_dout, FG_WAIT_n
    );

endinterface

// File: rtl/fg_slot_decode.sv
// Maps the latched pixel count to an access slot, flags the video-owned slots
// and produces the tile-data-valid strobe.
module fg_slot_decode
    import fg_arb_pkg::*;
(
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic [8:0] hpix_lt,
    input  logic       screen_flip,
    output logic       vid_owned,
    output logic       vid_latch
);

    logic [2:0] slot;
    logic       hpix_hi_unused;

    // Flipping the screen mirrors the slot order, so slot 7 lands on pixel 0.
    assign slot           = hpix_lt[2:0] ^ {3{screen_flip}};
    assign vid_owned      = is_vid_slot(slot);
    assign vid_latch      = rst_n & pix_ce & (slot == VID_SLOT_LAST);
    assign hpix_hi_unused = ^hpix_lt[8:3];

endmodule

// File: rtl/fg_vram_arbiter.sv
// Shares the single-port foreground tile RAM between video fetch and the Z80,
// stalling the CPU via FG_WAIT_n until a CPU-eligible slot is granted.
module fg_vram_arbiter
    import fg_arb_pkg::*;
(
    input  logic               master_clk,
    input  logic               nRESET,
    input  logic               pix_ce,
    input  logic [8:0]         HPIX_LT,
    input  logic               SCREEN_FLIP,
    input  logic [10:0]        vid_addr,
    fg_vram_arbiter_if.slave   cpu,
    input  logic [7:0]         ram_q_hi,
    input  logic [7:0]         ram_q_lo,
    output logic [10:0]        ram_addr,
    output logic [7:0]         ram_din,
    output logic               ram_we_hi,
    output logic               ram_we_lo,
    output logic               vid_latch
);

    arb_state_t state_q, state_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;
    logic       cs;
    logic       in_grant;
    logic       vid_owned;

    fg_slot_decode u_slot_decode (
        .rst_n       (nRESET),
        .pix_ce      (pix_ce),
        .hpix_lt     (HPIX_LT),
        .screen_flip (SCREEN_FLIP),
        .vid_owned   (vid_owned),
        .vid_latch   (vid_latch)
    );

    assign cs       = ~(cpu.CHARAM_n & cpu.ATRRAM_n);
    assign in_grant = (state_q == ST_GRANT);

    // DONE waits for cs to drop so a held select never produces a second access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs) state_d = ST_REQ;
            ST_REQ: begin
                if (!cs)
                    state_d = ST_IDLE;
                else if (!vid_owned)
                    state_d = ST_GRANT;
            end
            ST_GRANT: state_d = ST_DONE;
            ST_DONE:  if (!cs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // RAM data for the CPU address is valid during GRANT because the address
    // was already presented while waiting in REQ.
    always_comb begin
        cpu_dout_d = cpu_dout_q;
        if (in_grant && !cpu.Z80_RD_n)
            cpu_dout_d = !cpu.CHARAM_n ? ram_q_lo : ram_q_hi;
    end

    always_ff @(posedge master_clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            cpu_dout_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    // A grant in flight keeps the bus even if a flip moves the slot into video.
    assign ram_addr  = (vid_owned && !in_grant) ? vid_addr : cpu.CPU_ADDR;
    assign ram_din   = cpu.CPU_DIN;
    assign ram_we_lo = in_grant & ~cpu.Z80_WR_n & ~cpu.CHARAM_n;
    assign ram_we_hi = in_grant & ~cpu.Z80_WR_n & ~cpu.ATRRAM_n;

    assign cpu.cpu_dout  = cpu_dout_q;
    assign cpu.FG_WAIT_n = ~(cs & (state_q != ST_DONE));

endmodule

// File: tb/tb_fg_vram_arbiter.sv
// Directed bench for fg_vram_arbiter: a synchronous RAM model behind the DUT,
// a write scoreboard drained by a per-cycle monitor, and inline read/wait checks.
module tb_fg_vram_arbiter;

    typedef struct {
        logic        hi;
        logic        lo;
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    logic        master_clk;
    logic        nRESET;
    logic        pix_ce;
    logic [8:0]  HPIX_LT;
    logic        SCREEN_FLIP;
    logic [10:0] vid_addr;
    logic [7:0]  ram_q_hi;
    logic [7:0]  ram_q_lo;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we_hi;
    logic        ram_we_lo;
    logic        vid_latch;

    logic [7:0]  ramHi [0:2047];
    logic [7:0]  ramLo [0:2047];

    int          checks = 0;
    int          errors = 0;
    int          waitCycles;
    logic [9:0]  plan[$];
    wr_exp_t     expQ[$];
    wr_exp_t     eMon;
    logic [2:0]  expSlot;

    fg_vram_arbiter_if cpu_bus ();

    fg_vram_arbiter dut (
        .master_clk  (master_clk),
        .nRESET      (nRESET),
        .pix_ce      (pix_ce),
        .HPIX_LT     (HPIX_LT),
        .SCREEN_FLIP (SCREEN_FLIP),
        .vid_addr    (vid_addr),
        .cpu         (cpu_bus),
        .ram_q_hi    (ram_q_hi),
        .ram_q_lo    (ram_q_lo),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we_hi   (ram_we_hi),
        .ram_we_lo   (ram_we_lo),
        .vid_latch   (vid_latch)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    always @(posedge master_clk) begin
        if (ram_we_hi) ramHi[ram_addr] <= ram_din;
        if (ram_we_lo) ramLo[ram_addr] <= ram_din;
        ram_q_hi <= ramHi[ram_addr];
        ram_q_lo <= ramLo[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge master_clk);
    endtask

    task automatic applyStimulus(input logic charN, input logic atrN, input logic rdN,
                                 input logic wrN, input logic [10:0] addr, input logic [7:0] din);
        cpu_bus.CHARAM_n = charN;
        cpu_bus.ATRRAM_n = atrN;
        cpu_bus.Z80_RD_n = rdN;
        cpu_bus.Z80_WR_n = wrN;
        cpu_bus.CPU_ADDR = addr;
        cpu_bus.CPU_DIN  = din;
    endtask

    task automatic pushWrite(input logic hi, input logic lo, input logic [10:0] addr, input logic [7:0] data);
        wr_exp_t e;
        e.hi   = hi;
        e.lo   = lo;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Holds the CPU request until FG_WAIT_n releases, stepping the pixel plan each cycle.
    task automatic cpuAccess(input logic charN, input logic atrN, input logic rdN, input logic wrN,
                             input logic [10:0] addr, input logic [7:0] din, output int lowCycles);
        bit done;
        done      = 1'b0;
        lowCycles = 0;
        applyStimulus(charN, atrN, rdN, wrN, addr, din);
        for (int i = 0; i < 40 && !done; i++) begin
            if (plan.size() > 0)
                {pix_ce, HPIX_LT} = plan.pop_front();
            else
                pix_ce = 1'b0;
            #1;
            if (cpu_bus.FG_WAIT_n === 1'b1) begin
                done = 1'b1;
            end else begin
                lowCycles++;
                nextCycle();
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("[TB] FAIL wait_timeout: observed FG_WAIT_n low for %0d cycles, expected release within 40", lowCycles);
        end
        plan.delete();
    endtask

    task automatic holdDone(input int n);
        repeat (n) begin
            nextCycle();
            #1;
            checkOutput("done_hold_wait", 32'(cpu_bus.FG_WAIT_n), 32'(1));
        end
    endtask

    task automatic releaseCpu();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h000, 8'h00);
        nextCycle();
    endtask

    // Per-cycle monitor: video-slot ownership, latch strobe and write scoreboard.
    always begin
        @(negedge master_clk);
        #3;
        expSlot = SCREEN_FLIP ? (3'd7 - HPIX_LT[2:0]) : HPIX_LT[2:0];
        checkOutput("vid_latch", 32'(vid_latch), 32'(nRESET && pix_ce && expSlot == 3'd7));
        if (expSlot >= 3'd6) begin
            checkOutput("video_slot_addr", 32'(ram_addr), 32'(vid_addr));
            checkOutput("video_slot_no_write", 32'({ram_we_hi, ram_we_lo}), 32'(0));
        end
        if (ram_we_hi || ram_we_lo) begin
            checks++;
            assert (expQ.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_write: observed we_hi=%0b we_lo=%0b addr=0x%0h, expected no write",
                       ram_we_hi, ram_we_lo, ram_addr);
            end
            if (expQ.size() > 0) begin
                eMon = expQ.pop_front();
                checkOutput("write_enables", 32'({ram_we_hi, ram_we_lo}), 32'({eMon.hi, eMon.lo}));
                checkOutput("write_addr", 32'(ram_addr), 32'(eMon.addr));
                checkOutput("write_data", 32'(ram_din), 32'(eMon.data));
            end
        end
    end

    initial begin
        nRESET      = 1'b0;
        pix_ce      = 1'b1;
        HPIX_LT     = 9'd7;
        SCREEN_FLIP = 1'b0;
        vid_addr    = 11'h2B7;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h000, 8'h00);

        nextCycle();
        #1;
        checkOutput("reset_wait", 32'(cpu_bus.FG_WAIT_n), 32'(1));
        checkOutput("reset_dout", 32'(cpu_bus.cpu_dout), 32'(8'h00));
        checkOutput("reset_we", 32'({ram_we_hi, ram_we_lo}), 32'(0));
        checkOutput("reset_vid_latch", 32'(vid_latch), 32'(0));
        pix_ce  = 1'b0;
        HPIX_LT = 9'd1;
        nextCycle();
        nRESET = 1'b1;
        nextCycle();

        // Plain write in slot 1, select held through DONE.
        plan.push_back({1'b0, 9'd1});
        pushWrite(1'b0, 1'b1, 11'h123, 8'hA5);
        cpuAccess(1'b0, 1'b1, 1'b1, 1'b0, 11'h123, 8'hA5, waitCycles);
        checkOutput("write_wait_cycles", 32'(waitCycles), 32'(3));
        holdDone(3);
        releaseCpu();
        checkOutput("write_queue_empty", 32'(expQ.size()), 32'(0));

        // Same write issued in slot 6 waits out both video slots.
        plan.push_back({1'b0, 9'd6});
        plan.push_back({1'b0, 9'd6});
        plan.push_back({1'b1, 9'd7});
        plan.push_back({1'b0, 9'd7});
        plan.push_back({1'b1, 9'd8});
        pushWrite(1'b0, 1'b1, 11'h123, 8'hA5);
        cpuAccess(1'b0, 1'b1, 1'b1, 1'b0, 11'h123, 8'hA5, waitCycles);
        checkOutput("blocked_wait_cycles", 32'(waitCycles), 32'(6));
        releaseCpu();
        checkOutput("blocked_queue_empty", 32'(expQ.size()), 32'(0));

        plan.push_back({1'b0, 9'd2});
        pushWrite(1'b1, 1'b0, 11'h045, 8'h3C);
        cpuAccess(1'b1, 1'b0, 1'b1, 1'b0, 11'h045, 8'h3C, waitCycles);
        checkOutput("write_hi_wait_cycles", 32'(waitCycles), 32'(3));
        releaseCpu();

        plan.push_back({1'b0, 9'd2});
        cpuAccess(1'b1, 1'b0, 1'b0, 1'b1, 11'h045, 8'h00, waitCycles);
        checkOutput("read_hi_wait_cycles", 32'(waitCycles), 32'(3));
        checkOutput("read_hi_dout", 32'(cpu_bus.cpu_dout), 32'(8'h3C));
        releaseCpu();

        plan.push_back({1'b0, 9'd5});
        cpuAccess(1'b0, 1'b1, 1'b0, 1'b1, 11'h123, 8'h00, waitCycles);
        checkOutput("read_lo_slot5_wait", 32'(waitCycles), 32'(3));
        checkOutput("read_lo_slot5_dout", 32'(cpu_bus.cpu_dout), 32'(8'hA5));
        releaseCpu();

        // Flipped screen: pixel 0 is slot 7, pixel 7 is slot 0.
        SCREEN_FLIP = 1'b1;
        plan.push_back({1'b1, 9'h010});
        plan.push_back({1'b0, 9'h010});
        plan.push_back({1'b1, 9'h017});
        pushWrite(1'b0, 1'b1, 11'h321, 8'hC3);
        cpuAccess(1'b0, 1'b1, 1'b1, 1'b0, 11'h321, 8'hC3, waitCycles);
        checkOutput("flip_wait_cycles", 32'(waitCycles), 32'(4));
        releaseCpu();
        checkOutput("flip_queue_empty", 32'(expQ.size()), 32'(0));

        plan.push_back({1'b0, 9'h017});
        cpuAccess(1'b0, 1'b1, 1'b0, 1'b1, 11'h321, 8'h00, waitCycles);
        checkOutput("flip_read_dout", 32'(cpu_bus.cpu_dout), 32'(8'hC3));
        releaseCpu();

        // Abort: select dropped while parked in REQ behind video.
        SCREEN_FLIP = 1'b0;
        HPIX_LT     = 9'd6;
        pix_ce      = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h055, 8'h11);
        #1;
        checkOutput("abort_wait_idle", 32'(cpu_bus.FG_WAIT_n), 32'(0));
        nextCycle();
        #1;
        checkOutput("abort_wait_req", 32'(cpu_bus.FG_WAIT_n), 32'(0));
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h055, 8'h11);
        #1;
        checkOutput("abort_wait_dropped", 32'(cpu_bus.FG_WAIT_n), 32'(1));
        nextCycle();
        plan.push_back({1'b0, 9'd8});
        cpuAccess(1'b0, 1'b1, 1'b0, 1'b1, 11'h123, 8'h00, waitCycles);
        checkOutput("abort_fresh_wait", 32'(waitCycles), 32'(3));
        checkOutput("abort_fresh_dout", 32'(cpu_bus.cpu_dout), 32'(8'hA5));
        releaseCpu();

        // Reset pulsed while the write is being granted.
        HPIX_LT = 9'd3;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h123, 8'h77);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("grant_we_lo_before_reset", 32'(ram_we_lo), 32'(1));
        nRESET = 1'b0;
        #1;
        checkOutput("reset_in_grant_we", 32'({ram_we_hi, ram_we_lo}), 32'(0));
        checkOutput("reset_in_grant_dout", 32'(cpu_bus.cpu_dout), 32'(8'h00));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h000, 8'h00);
        #1;
        checkOutput("reset_idle_wait", 32'(cpu_bus.FG_WAIT_n), 32'(1));
        nextCycle();
        nRESET = 1'b1;
        plan.push_back({1'b0, 9'd3});
        cpuAccess(1'b0, 1'b1, 1'b0, 1'b1, 11'h123, 8'h00, waitCycles);
        checkOutput("post_reset_wait", 32'(waitCycles), 32'(3));
        checkOutput("post_reset_dout", 32'(cpu_bus.cpu_dout), 32'(8'hA5));
        releaseCpu();

        // Both selects active write both byte lanes together.
        plan.push_back({1'b0, 9'd4});
        pushWrite(1'b1, 1'b1, 11'h200, 8'h5A);
        cpuAccess(1'b0, 1'b0, 1'b1, 1'b0, 11'h200, 8'h5A, waitCycles);
        checkOutput("dual_wait_cycles", 32'(waitCycles), 32'(3));
        releaseCpu();

        plan.push_back({1'b0, 9'd4});
        cpuAccess(1'b1, 1'b0, 1'b0, 1'b1, 11'h200, 8'h00, waitCycles);
        checkOutput("dual_read_hi_dout", 32'(cpu_bus.cpu_dout), 32'(8'h5A));
        releaseCpu();

        nextCycle();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
